// File: rtl/stream_packet_arbiter.sv
// Round-robin packet arbiter: grants one requester at a time and holds the grant
// until the end-of-packet beat, with an optional stall watchdog and synchronous flush.
module stream_packet_arbiter #(
   parameter int NumIn     = 4,
   parameter int DataWidth = 32,
   parameter int Timeout   = 255,
   localparam int IdxW     = (NumIn > 1) ? $clog2(NumIn) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic [NumIn-1:0]           valid_i,
   output logic [NumIn-1:0]           ready_o,
   input  logic [NumIn*DataWidth-1:0] data_i,
   input  logic [NumIn-1:0]           last_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [DataWidth-1:0]       data_o,
   output logic                       last_o,
   output logic [IdxW-1:0]            idx_o,
   output logic                       busy_o,
   output logic                       timeout_o
);

   localparam int CntW = (Timeout > 255) ? $clog2(Timeout + 1) : 8;
   localparam logic [CntW-1:0] TmoLast = CntW'((Timeout == 0) ? 0 : Timeout - 1);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [IdxW-1:0]     rr_q, rr_d;
   logic [IdxW-1:0]     lock_q, lock_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                tmo_q, tmo_d;

   logic [IdxW-1:0]     sel;
   logic [IdxW-1:0]     route;
   logic                found;
   logic                valid_sel;
   logic                grant_en;
   logic                hs;

   function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
      if (int'(i) >= NumIn - 1) return '0;
      return i + IdxW'(1);
   endfunction

   // Cyclic priority from rr_q: first pass covers rr_q..NumIn-1, second wraps to 0..rr_q-1.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      sel   = rr_q;
      found = 1'b0;
      for (int i = 0; i < NumIn; i++) begin
         if (!found && valid_i[i] && (IdxW'(i) >= rr_q)) begin
            sel   = IdxW'(i);
            found = 1'b1;
         end
      end
      for (int i = 0; i < NumIn; i++) begin
         if (!found && valid_i[i]) begin
            sel   = IdxW'(i);
            found = 1'b1;
         end
      end
   end

   assign route = (state_q == LOCK) ? lock_q : sel;

   always_comb begin
      valid_sel = 1'b0;
      last_o    = 1'b0;
      data_o    = '0;
      for (int i = 0; i < NumIn; i++) begin
         if (IdxW'(i) == route) begin
            valid_sel = valid_i[i];
            last_o    = last_i[i];
            data_o    = data_i[i*DataWidth +: DataWidth];
         end
      end
   end

   // valid_o never looks at ready_i, so downstream may safely make ready depend on valid.
   assign valid_o  = ((state_q == LOCK) ? valid_sel : |valid_i) & ~flush_i;
   assign grant_en = ~flush_i & ((state_q == LOCK) | (|valid_i));
   assign idx_o    = route;
   assign hs       = valid_o & ready_i;

   always_comb begin
      ready_o = '0;
      for (int i = 0; i < NumIn; i++) begin
         ready_o[i] = grant_en & ready_i & (IdxW'(i) == route);
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      lock_d  = lock_q;
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
      if (flush_i) begin
         state_d = IDLE;
         rr_d    = '0;
         lock_d  = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (hs && last_o) begin
                  rr_d = next_idx(sel);
               end else if (valid_o) begin
                  // Lock on a stalled first beat too, so data and index hold steady.
                  state_d = LOCK;
                  lock_d  = sel;
                  cnt_d   = '0;
               end
            end
            LOCK: begin
               if (hs) begin
                  if (last_o) begin
                     state_d = IDLE;
                     rr_d    = next_idx(lock_q);
                  end else begin
                     cnt_d = '0;
                  end
               end else if ((Timeout != 0) && (cnt_q == TmoLast)) begin
                  tmo_d   = 1'b1;
                  state_d = IDLE;
                  rr_d    = next_idx(lock_q);
                  cnt_d   = '0;
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rr_q    <= '0;
         lock_q  <= '0;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         lock_q  <= lock_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign busy_o    = (state_q == LOCK);
   assign timeout_o = tmo_q;

endmodule
